mcsr_unit: RTL and testbench

Parametrised machine-mode CSR unit, the next generation of the core's CSR file.
- Adds writable vectored mtvec, mie/mip interrupt gating, 64-bit mcycle/minstret and NUM_HPM event counters with mcountinhibit.
- Sits beside the execute stage: it decodes CSR accesses, records trap state, and supplies the trap target and the interrupt request to the control FSM.

---
 rtl/csr_pkg.sv | 70 +++++++
 rtl/csr_counter64.sv | 36 +++
 rtl/mcsr_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_mcsr_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, write
// operation encoding, bit positions and the read-modify-write helper.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // Counter pages: 0xBxx machine counters, 0xCxx read-only user shadows
  localparam logic [3:0] CSR_MCNT_PAGE = 4'hB;
  localparam logic [3:0] CSR_UCNT_PAGE = 4'hC;

  typedef enum logic [1:0] {
    WT_NONE  = 2'b00,
    WT_WRITE = 2'b01,
    WT_SET   = 2'b10,
    WT_CLEAR = 2'b11
  } write_type_e;

  // mstatus / mip bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  // Interrupt cause codes
  localparam logic [4:0] IRQ_CODE_SW    = 5'd3;
  localparam logic [4:0] IRQ_CODE_TIMER = 5'd7;
  localparam logic [4:0] IRQ_CODE_EXT   = 5'd11;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

  // New register value for a CSR write/set/clear; none leaves it unchanged
  function automatic logic [31:0] csr_write_value(input logic [1:0]  wt,
                                                  input logic [31:0] cur,
                                                  input logic [31:0] wdata);
    logic [31:0] res;
    res = cur;
    case (write_type_e'(wt))
      WT_WRITE: res = wdata;
      WT_SET:   res = cur | wdata;
      WT_CLEAR: res = cur & ~wdata;
      default:  res = cur;
    endcase
    return res;
  endfunction

  // Writable bits of mcountinhibit: CY, IR and one bit per implemented HPM
  function automatic logic [31:0] mcountinhibit_mask(input int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < num_hpm; i++) m[i+3] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half write access. A write to either half
// suppresses the increment (and its carry) for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] value_q;
  logic [63:0] value_d;

  // Next count: writes replace a half, otherwise count when enabled
  always_comb begin
    value_d = value_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) value_d[31:0]  = wdata;
      if (wr_hi) value_d[63:32] = wdata;
    end else if (inc && !inhibit) begin
      value_d = value_q + 64'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/mcsr_unit.sv
// Machine-mode CSR unit: CSR decode and read/write, trap/mret state,
// interrupt gating and the machine counters.
module mcsr_unit
  import csr_pkg::*;
#(
  parameter int          NUM_HPM     = 0,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] RESET_MTVEC = 32'h4,
  parameter bit          VECTOR_EN   = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [11:0]                         csr_addr,
  input  logic [31:0]                         csr_wdata,
  input  logic                                read,
  input  logic                                write,
  input  logic [1:0]                          write_type,
  output logic [31:0]                         csr_rdata,
  output logic                                invalid,
  input  logic                                trap,
  input  logic                                trap_is_irq,
  input  logic [4:0]                          trap_cause,
  input  logic [31:0]                         trap_pc,
  input  logic [31:0]                         trap_val,
  input  logic                                ret,
  input  logic                                retire,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic                                ext_irq,
  input  logic                                timer_irq,
  input  logic                                sw_irq,
  output logic                                irq_pending,
  output logic [4:0]                          irq_cause,
  output logic [31:0]                         trap_vector,
  output logic [31:0]                         epc_out
);

  localparam int          NCNT     = 2 + NUM_HPM;
  localparam logic [5:0]  HPM_END  = 6'(3 + NUM_HPM);
  localparam logic [31:0] MCI_MASK = mcountinhibit_mask(NUM_HPM);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mcountinhibit_q, mcountinhibit_d;

  logic [31:0] mip_w, mstatus_rd, rdata, wval, pend;
  logic [63:0] cnt_rd;
  logic        cnt_hit, cnt_hi, cnt_wr_en, unimpl, invalid_acc, wr_en;
  logic [4:0]  cnt_sel;
  logic [NCNT-1:0] cnt_inc, cnt_inh, cnt_wr_lo, cnt_wr_hi;
  logic [63:0] cnt_val [NCNT];

  logic unused_trap_pc;
  assign unused_trap_pc = ^trap_pc[1:0];

  // Live interrupt lines and the mstatus read image (MPP fixed at 11)
  always_comb begin
    mip_w = '0;
    mip_w[MIP_MEIP] = ext_irq;
    mip_w[MIP_MTIP] = timer_irq;
    mip_w[MIP_MSIP] = sw_irq;
    mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  end

  // Counter address decode: index 0 = mcycle, 2 = minstret, 3.. = hpm
  always_comb begin
    cnt_hit = 1'b0;
    cnt_hi  = csr_addr[7];
    cnt_sel = '0;
    if (csr_addr[6:5] == 2'b00) begin
      if (csr_addr[4:0] == 5'd0 &&
          (csr_addr[11:8] == CSR_MCNT_PAGE || csr_addr[11:8] == CSR_UCNT_PAGE)) begin
        cnt_hit = 1'b1;
        cnt_sel = 5'd0;
      end else if (csr_addr[4:0] == 5'd2 &&
          (csr_addr[11:8] == CSR_MCNT_PAGE || csr_addr[11:8] == CSR_UCNT_PAGE)) begin
        cnt_hit = 1'b1;
        cnt_sel = 5'd1;
      end else if (csr_addr[11:8] == CSR_MCNT_PAGE && csr_addr[4:0] >= 5'd3 &&
                   {1'b0, csr_addr[4:0]} < HPM_END) begin
        cnt_hit = 1'b1;
        cnt_sel = csr_addr[4:0] - 5'd1;
      end
    end
  end

  // Read data selection; addresses outside the CSR map raise unimpl
  always_comb begin
    cnt_rd = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (cnt_sel == 5'(k)) cnt_rd = cnt_val[k];
    end
    rdata  = '0;
    unimpl = 1'b0;
    if (cnt_hit) begin
      rdata = cnt_hi ? cnt_rd[63:32] : cnt_rd[31:0];
    end else begin
      case (csr_addr)
        CSR_MSTATUS:       rdata = mstatus_rd;
        CSR_MISA:          rdata = MISA_VALUE;
        CSR_MIE:           rdata = mie_q;
        CSR_MTVEC:         rdata = mtvec_q;
        CSR_MCOUNTINHIBIT: rdata = mcountinhibit_q;
        CSR_MSCRATCH:      rdata = mscratch_q;
        CSR_MEPC:          rdata = mepc_q;
        CSR_MCAUSE:        rdata = mcause_q;
        CSR_MTVAL:         rdata = mtval_q;
        CSR_MIP:           rdata = mip_w;
        CSR_MVENDORID:     rdata = '0;
        CSR_MARCHID:       rdata = '0;
        CSR_MIMPID:        rdata = '0;
        CSR_MHARTID:       rdata = HART_ID;
        default:           unimpl = 1'b1;
      endcase
    end
  end

  // Access legality and the qualified write strobe (trap and mret win)
  always_comb begin
    invalid_acc = unimpl ||
                  (write && write_type != WT_NONE && csr_addr[11:10] == 2'b11) ||
                  (write && csr_addr == CSR_MIP);
    wr_en     = write && write_type != WT_NONE && !invalid_acc && !trap && !ret;
    cnt_wr_en = wr_en && cnt_hit && csr_addr[11:8] == CSR_MCNT_PAGE;
    wval      = csr_write_value(write_type, rdata, csr_wdata);
  end

  assign csr_rdata = rdata;
  assign invalid   = (read || write) && invalid_acc;

  // Next state of the non-counter registers: trap > mret > CSR write
  always_comb begin
    mstatus_mie_d   = mstatus_mie_q;
    mstatus_mpie_d  = mstatus_mpie_q;
    mie_d           = mie_q;
    mtvec_d         = mtvec_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    mcountinhibit_d = mcountinhibit_q;
    if (trap) begin
      mepc_d         = {trap_pc[31:2], 2'b00};
      mcause_d       = {trap_is_irq, 26'b0, trap_cause};
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (ret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wval[MSTATUS_MIE];
          mstatus_mpie_d = wval[MSTATUS_MPIE];
        end
        CSR_MIE:           mie_d = wval & MIE_MASK;
        CSR_MTVEC:         mtvec_d = {wval[31:2],
                                      (VECTOR_EN && wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
        CSR_MCOUNTINHIBIT: mcountinhibit_d = wval & MCI_MASK;
        CSR_MSCRATCH:      mscratch_d = wval;
        CSR_MEPC:          mepc_d = wval;
        CSR_MCAUSE:        mcause_d = wval;
        CSR_MTVAL:         mtval_d = wval;
        default: ;
      endcase
    end
  end

  // CSR state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q   <= 1'b0;
      mstatus_mpie_q  <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= RESET_MTVEC;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mcountinhibit_q <= '0;
    end else begin
      mstatus_mie_q   <= mstatus_mie_d;
      mstatus_mpie_q  <= mstatus_mpie_d;
      mie_q           <= mie_d;
      mtvec_q         <= mtvec_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      mcountinhibit_q <= mcountinhibit_d;
    end
  end

  // Interrupt request, cause priority (11 > 3 > 7) and trap target
  always_comb begin
    pend        = mie_q & mip_w;
    irq_pending = mstatus_mie_q && (|pend);
    if (pend[MIP_MEIP])      irq_cause = IRQ_CODE_EXT;
    else if (pend[MIP_MSIP]) irq_cause = IRQ_CODE_SW;
    else if (pend[MIP_MTIP]) irq_cause = IRQ_CODE_TIMER;
    else                     irq_cause = 5'd0;
    if (mtvec_q[1:0] == 2'b01 && trap_is_irq)
      trap_vector = {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause, 2'b00};
    else
      trap_vector = {mtvec_q[31:2], 2'b00};
  end

  assign epc_out = mepc_q;

  // Counter instances: 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
  for (genvar k = 0; k < NCNT; k++) begin : g_cnt
    localparam int INH_BIT = (k == 0) ? 0 : ((k == 1) ? 2 : k + 1);
    if (k == 0) begin : g_cycle
      assign cnt_inc[k] = 1'b1;
    end else if (k == 1) begin : g_instret
      assign cnt_inc[k] = retire;
    end else begin : g_hpm
      assign cnt_inc[k] = hpm_event[k-2];
    end
    assign cnt_inh[k]   = mcountinhibit_q[INH_BIT];
    assign cnt_wr_lo[k] = cnt_wr_en && !cnt_hi && cnt_sel == 5'(k);
    assign cnt_wr_hi[k] = cnt_wr_en &&  cnt_hi && cnt_sel == 5'(k);
    csr_counter64 u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (cnt_inc[k]),
      .inhibit (cnt_inh[k]),
      .wr_lo   (cnt_wr_lo[k]),
      .wr_hi   (cnt_wr_hi[k]),
      .wdata   (wval),
      .value   (cnt_val[k])
    );
  end

  if (NUM_HPM == 0) begin : g_no_hpm
    logic unused_hpm;
    assign unused_hpm = ^hpm_event;
  end

endmodule

// File: tb/tb_mcsr_unit.sv
// Directed bench for mcsr_unit: register vector table plus hand-written
// sequences for counters, interrupts, trap and mret.
`timescale 1ns/1ps
module tb_mcsr_unit;

  localparam int          NUM_HPM = 2;
  localparam logic [31:0] HART_ID = 32'h5;

  logic        clk, rst;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        read, write, invalid;
  logic [1:0]  write_type;
  logic        trap, trap_is_irq, ret, retire;
  logic [4:0]  trap_cause, irq_cause;
  logic [31:0] trap_pc, trap_val, trap_vector, epc_out;
  logic [NUM_HPM-1:0] hpm_event;
  logic        ext_irq, timer_irq, sw_irq, irq_pending;

  mcsr_unit #(
    .NUM_HPM(NUM_HPM), .HART_ID(HART_ID), .RESET_MTVEC(32'h4), .VECTOR_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .read(read), .write(write), .write_type(write_type),
    .csr_rdata(csr_rdata), .invalid(invalid),
    .trap(trap), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .ret(ret), .retire(retire),
    .hpm_event(hpm_event), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .sw_irq(sw_irq), .irq_pending(irq_pending), .irq_cause(irq_cause),
    .trap_vector(trap_vector), .epc_out(epc_out)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wt;
    logic        winv;
    logic [31:0] rdata;
    logic        rinv;
  } vec_t;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    read = 0; write = 0; write_type = 2'b00; trap = 0; trap_is_irq = 0;
    trap_cause = 0; trap_pc = 0; trap_val = 0; ret = 0; retire = 0; hpm_event = '0;
  endtask

  // One-cycle CSR write; invalid is checked before the edge
  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] wt,
                        input logic exp_inv, input string name);
    csr_addr = a; csr_wdata = d; write = 1; write_type = wt;
    #1;
    check({name, " wr_invalid"}, 32'(invalid), 32'(exp_inv));
    tick();
    write = 0; write_type = 2'b00;
  endtask

  // One-cycle CSR read with expected data through the queue
  task automatic csr_rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    csr_addr = a; read = 1;
    #1;
    check(name, csr_rdata, exp_q.pop_front());
    check({name, " rd_invalid"}, 32'(invalid), 32'd0);
    read = 0;
    @(negedge clk);
  endtask

  task automatic csr_rd_inv(input logic [11:0] a, input string name);
    csr_addr = a; read = 1;
    #1;
    check({name, " rd_invalid"}, 32'(invalid), 32'd1);
    read = 0;
    @(negedge clk);
  endtask

  // Two reads in the same cycle so both counter halves are coherent
  task automatic csr_rd2(input logic [11:0] a1, input logic [31:0] e1,
                         input logic [11:0] a2, input logic [31:0] e2, input string name);
    read = 1;
    csr_addr = a1; #1; check({name, " lo"}, csr_rdata, e1);
    csr_addr = a2; #1; check({name, " hi"}, csr_rdata, e2);
    read = 0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{12'h340, 32'hDEADBEEF, 2'b01, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{12'h340, 32'h00000010, 2'b10, 1'b0, 32'hDEADBEFF, 1'b0};
    vecs[2]  = '{12'h340, 32'hDEAD0000, 2'b11, 1'b0, 32'h0000BEFF, 1'b0};
    vecs[3]  = '{12'h340, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h0000BEFF, 1'b0};
    vecs[4]  = '{12'h304, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h00000888, 1'b0};
    vecs[5]  = '{12'h304, 32'h00000080, 2'b11, 1'b0, 32'h00000808, 1'b0};
    vecs[6]  = '{12'h305, 32'h00001002, 2'b01, 1'b0, 32'h00001000, 1'b0};
    vecs[7]  = '{12'h305, 32'h00001003, 2'b01, 1'b0, 32'h00001000, 1'b0};
    vecs[8]  = '{12'h305, 32'h00001001, 2'b01, 1'b0, 32'h00001001, 1'b0};
    vecs[9]  = '{12'h300, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h00001888, 1'b0};
    vecs[10] = '{12'h300, 32'h00000000, 2'b01, 1'b0, 32'h00001800, 1'b0};
    vecs[11] = '{12'h320, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0000001D, 1'b0};
    vecs[12] = '{12'h320, 32'h00000000, 2'b01, 1'b0, 32'h00000000, 1'b0};
    vecs[13] = '{12'h342, 32'h8000000B, 2'b01, 1'b0, 32'h8000000B, 1'b0};
    vecs[14] = '{12'h344, 32'h00000888, 2'b01, 1'b1, 32'h00000000, 1'b0};
    vecs[15] = '{12'h301, 32'h00000000, 2'b01, 1'b0, 32'h40000100, 1'b0};
    vecs[16] = '{12'hC02, 32'h00000005, 2'b01, 1'b1, 32'h00000011, 1'b0};
    vecs[17] = '{12'hB05, 32'h00000001, 2'b01, 1'b1, 32'h00000000, 1'b1};
    vecs[18] = '{12'h7C0, 32'h00000001, 2'b01, 1'b1, 32'h00000000, 1'b1};
    vecs[19] = '{12'h343, 32'h00000055, 2'b10, 1'b0, 32'h00000055, 1'b0};

    idle();
    csr_addr = 0; csr_wdata = 0; ext_irq = 0; timer_irq = 0; sw_irq = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state, read while reset is still held
    #1;
    check("rst irq_pending", 32'(irq_pending), 32'd0);
    check("rst epc_out", epc_out, 32'd0);
    check("rst trap_vector", trap_vector, 32'h4);
    csr_rd(12'h300, 32'h00001800, "rst mstatus");
    csr_rd(12'h305, 32'h00000004, "rst mtvec");
    csr_rd(12'h304, 32'h0, "rst mie");
    csr_rd(12'h341, 32'h0, "rst mepc");
    csr_rd(12'h342, 32'h0, "rst mcause");
    csr_rd(12'h340, 32'h0, "rst mscratch");
    csr_rd(12'h320, 32'h0, "rst mcountinhibit");
    csr_rd(12'h301, 32'h40000100, "misa");
    csr_rd(12'hF11, 32'h0, "mvendorid");
    csr_rd(12'hB00, 32'h0, "rst mcycle");
    rst = 0;

    // mcycle counting and inhibit; each read/write costs one cycle
    tick(5);
    csr_rd(12'hB00, 32'd5, "mcycle after 5");             // then 6
    csr_wr(12'h320, 32'h1, 2'b01, 1'b0, "inhibit on");    // edge -> 7, inhibited
    tick(3);
    csr_rd(12'hB00, 32'd7, "mcycle inhibited");
    csr_rd(12'hC00, 32'd7, "cycle shadow");
    csr_wr(12'hF14, 32'h1, 2'b01, 1'b1, "mhartid write");
    csr_rd(12'hF14, HART_ID, "mhartid");

    // Low-to-high carry
    csr_wr(12'hB00, 32'hFFFFFFFF, 2'b01, 1'b0, "mcycle lo");
    csr_wr(12'hB80, 32'h0, 2'b01, 1'b0, "mcycle hi");
    csr_wr(12'h320, 32'h0, 2'b01, 1'b0, "inhibit off");
    tick(2);
    csr_rd2(12'hB00, 32'd1, 12'hB80, 32'd1, "mcycle carry");

    // Write cycle coinciding with retire keeps the written value
    retire = 1;
    csr_wr(12'hB02, 32'h10, 2'b01, 1'b0, "minstret wr");
    retire = 0;
    csr_rd(12'hB02, 32'h10, "minstret written");
    retire = 1; tick(); retire = 0;
    csr_rd(12'hB02, 32'h11, "minstret retire");

    // Register vector table
    for (int i = 0; i < 20; i++) begin
      csr_wr(vecs[i].addr, vecs[i].wdata, vecs[i].wt, vecs[i].winv, $sformatf("vec%0d", i));
      if (vecs[i].rinv) csr_rd_inv(vecs[i].addr, $sformatf("vec%0d", i));
      else              csr_rd(vecs[i].addr, vecs[i].rdata, $sformatf("vec%0d", i));
    end

    // Interrupt gating and cause priority
    csr_wr(12'h300, 32'h8, 2'b01, 1'b0, "mstatus MIE");
    csr_wr(12'h304, 32'h800, 2'b01, 1'b0, "mie ext");
    ext_irq = 1; #1;
    check("ext pending", 32'(irq_pending), 32'd1);
    check("ext cause", 32'(irq_cause), 32'd11);
    sw_irq = 1; #1;
    check("ext+sw cause", 32'(irq_cause), 32'd11);
    @(negedge clk);
    csr_rd(12'h344, 32'h808, "mip live");
    csr_wr(12'h304, 32'h8, 2'b01, 1'b0, "mie sw");
    #1;
    check("sw cause", 32'(irq_cause), 32'd3);
    check("sw pending", 32'(irq_pending), 32'd1);
    @(negedge clk);
    timer_irq = 1;
    csr_wr(12'h304, 32'h80, 2'b01, 1'b0, "mie timer");
    #1;
    check("timer cause", 32'(irq_cause), 32'd7);
    @(negedge clk);
    csr_wr(12'h304, 32'h8, 2'b01, 1'b0, "mie sw again");

    // Trap target, then a trap that drops a simultaneous mscratch write
    trap_is_irq = 0; trap_cause = 5'd2; #1;
    check("exc vector", trap_vector, 32'h1000);
    @(negedge clk);
    trap = 1; trap_is_irq = 1; trap_cause = 5'd7; trap_pc = 32'h2003; trap_val = 32'hAB;
    csr_addr = 12'h340; csr_wdata = 32'h12345678; write = 1; write_type = 2'b01;
    #1;
    check("irq vector", trap_vector, 32'h101C);
    tick();
    idle();
    #1;
    check("trap irq_pending", 32'(irq_pending), 32'd0);
    check("trap epc_out", epc_out, 32'h2000);
    @(negedge clk);
    csr_rd(12'h341, 32'h2000, "trap mepc");
    csr_rd(12'h342, 32'h80000007, "trap mcause");
    csr_rd(12'h343, 32'hAB, "trap mtval");
    csr_rd(12'h300, 32'h1880, "trap mstatus");
    csr_rd(12'h340, 32'h0000BEFF, "trap mscratch");

    // mret with a dropped mstatus write
    ret = 1; csr_addr = 12'h300; csr_wdata = 32'h0; write = 1; write_type = 2'b01;
    tick();
    idle();
    #1;
    check("ret irq_pending", 32'(irq_pending), 32'd1);
    check("ret epc_out", epc_out, 32'h2000);
    @(negedge clk);
    csr_rd(12'h300, 32'h1888, "ret mstatus");
    ext_irq = 0; timer_irq = 0; sw_irq = 0;

    // HPM counters
    repeat (4) begin
      hpm_event = 2'b10; tick();
      hpm_event = 2'b00; tick();
    end
    csr_rd(12'hB04, 32'd4, "hpm4 count");
    csr_rd(12'hB03, 32'd0, "hpm3 idle");
    csr_rd(12'hB84, 32'd0, "hpm4 hi");
    csr_rd_inv(12'hB05, "hpm5");
    csr_wr(12'h320, 32'h10, 2'b01, 1'b0, "inhibit hpm4");
    hpm_event = 2'b11; tick(2); hpm_event = 2'b00;
    csr_rd(12'hB04, 32'd4, "hpm4 inhibited");
    csr_rd(12'hB03, 32'd2, "hpm3 counted");
    csr_wr(12'hB03, 32'hFFFFFFFF, 2'b01, 1'b0, "hpm3 lo");
    csr_wr(12'hB83, 32'hFFFFFFFF, 2'b01, 1'b0, "hpm3 hi");
    hpm_event = 2'b01; tick(); hpm_event = 2'b00;
    csr_rd2(12'hB03, 32'd0, 12'hB83, 32'd0, "hpm3 wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
